// File: rtl/pwm_backlight_block.sv
// pwm_backlight_block
//   USI bus slave generating the LCD backlight PWM. It decodes its block
//   select from the shared slave-side address and exposes CTRL, PERIOD,
//   TARGET, RAMPDIV and STATUS registers. The PWM frame and duty are taken
//   from shadow copies that reload only at a frame boundary, so pulses are
//   never shortened or split. An optional linear ramp walks the current duty
//   one step at a time toward the programmed target.
//
// Ports
//   iSysClk    : system clock, rising edge
//   iSysRst    : asynchronous active-high reset
//   iSUsiWd    : bus write data
//   iSUsiAdrs  : bus address, [pBusAdrsBit -: pBlockAdrsMap] = block select,
//                low bits = byte register offset
//   iSUsiWCke  : 1 = write cycle, 0 = read cycle
//   oSUsiRd    : read data, zero when oSUsiVd is low
//   oSUsiVd    : read data valid, one cycle after a read request
//   oPwm       : registered backlight PWM output
module pwm_backlight_block #(
  parameter int                       pBlockAdrsMap = 8,
  parameter logic [pBlockAdrsMap-1:0] pAdrsMap      = 8'h02,
  parameter int                       pBusAdrsBit   = 15
) (
  input  logic                 iSysClk,
  input  logic                 iSysRst,
  input  logic [31:0]          iSUsiWd,
  input  logic [pBusAdrsBit:0] iSUsiAdrs,
  input  logic                 iSUsiWCke,
  output logic [31:0]          oSUsiRd,
  output logic                 oSUsiVd,
  output logic                 oPwm
);

  localparam int OFS_W = pBusAdrsBit + 1 - pBlockAdrsMap;

  localparam logic [OFS_W-1:0] OFS_CTRL    = OFS_W'(8'h00);
  localparam logic [OFS_W-1:0] OFS_PERIOD  = OFS_W'(8'h04);
  localparam logic [OFS_W-1:0] OFS_TARGET  = OFS_W'(8'h08);
  localparam logic [OFS_W-1:0] OFS_RAMPDIV = OFS_W'(8'h0C);
  localparam logic [OFS_W-1:0] OFS_STATUS  = OFS_W'(8'h10);

  typedef enum logic [1:0] {
    RAMP_IDLE,
    RAMP_UP,
    RAMP_DOWN
  } ramp_state_e;

  // Bus decode
  logic [pBlockAdrsMap-1:0] blk_sel;
  logic [OFS_W-1:0]         ofs;
  logic                     sel;
  logic                     wr_en;
  logic                     rd_en;
  logic                     unused_wd_hi;

  assign blk_sel      = iSUsiAdrs[pBusAdrsBit -: pBlockAdrsMap];
  assign ofs          = iSUsiAdrs[OFS_W-1:0];
  assign sel          = (blk_sel == pAdrsMap);
  assign wr_en        = sel & iSUsiWCke;
  assign rd_en        = sel & ~iSUsiWCke;
  assign unused_wd_hi = ^iSUsiWd[31:16];

  // State
  logic [1:0]  ctrl_q,     ctrl_d;
  logic [15:0] period_q,   period_d;
  logic [15:0] target_q,   target_d;
  logic [15:0] rampdiv_q,  rampdiv_d;
  logic [15:0] cur_q,      cur_d;
  logic [15:0] rc_q,       rc_d;
  logic [15:0] cnt_q,      cnt_d;
  logic [15:0] period_a_q, period_a_d;
  logic [15:0] duty_a_q,   duty_a_d;
  logic        pwm_q,      pwm_d;
  logic [31:0] rd_q,       rd_d;
  logic        vd_q,       vd_d;

  ramp_state_e ramp_state;
  logic        en;
  logic        pol;
  logic        frame_end;

  assign en  = ctrl_q[0];
  assign pol = ctrl_q[1];

  // Register file writes
  always_comb begin
    ctrl_d    = ctrl_q;
    period_d  = period_q;
    target_d  = target_q;
    rampdiv_d = rampdiv_q;
    if (wr_en) begin
      case (ofs)
        OFS_CTRL:    ctrl_d    = iSUsiWd[1:0];
        OFS_PERIOD:  period_d  = iSUsiWd[15:0];
        OFS_TARGET:  target_d  = iSUsiWd[15:0];
        OFS_RAMPDIV: rampdiv_d = iSUsiWd[15:0];
        default:     ;
      endcase
    end
  end

  // Ramp direction, re-derived every cycle from CUR vs TARGET
  always_comb begin
    ramp_state = RAMP_IDLE;
    if (cur_q < target_q) begin
      ramp_state = RAMP_UP;
    end else if (cur_q > target_q) begin
      ramp_state = RAMP_DOWN;
    end
  end

  // Ramp step: one count toward TARGET per RAMPDIV clocks. A single step can
  // never cross TARGET, so no overshoot is possible.
  always_comb begin
    cur_d = cur_q;
    rc_d  = rc_q;
    if (rampdiv_q == 16'd0) begin
      cur_d = target_q;
      rc_d  = 16'd0;
    end else begin
      case (ramp_state)
        RAMP_UP, RAMP_DOWN: begin
          if (rc_q == rampdiv_q - 16'd1) begin
            cur_d = (ramp_state == RAMP_UP) ? cur_q + 16'd1 : cur_q - 16'd1;
            rc_d  = 16'd0;
          end else begin
            rc_d = rc_q + 16'd1;
          end
        end
        default: rc_d = 16'd0;
      endcase
    end
    // A new divider restarts the step interval; a new target does not.
    if (wr_en && (ofs == OFS_RAMPDIV)) begin
      rc_d = 16'd0;
    end
  end

  // Frame counter and shadow reload. The shadows follow the live values
  // while disabled so enabling starts a clean frame with current settings.
  always_comb begin
    frame_end  = (cnt_q >= period_a_q);
    cnt_d      = cnt_q + 16'd1;
    period_a_d = period_a_q;
    duty_a_d   = duty_a_q;
    if (!en || frame_end) begin
      cnt_d      = 16'd0;
      period_a_d = period_q;
      duty_a_d   = cur_q;
    end
    pwm_d = (en & (cnt_q < duty_a_q)) ^ pol;
  end

  // Read data path
  always_comb begin
    rd_d = 32'd0;
    vd_d = rd_en;
    if (rd_en) begin
      case (ofs)
        OFS_CTRL:    rd_d = {30'd0, ctrl_q};
        OFS_PERIOD:  rd_d = {16'd0, period_q};
        OFS_TARGET:  rd_d = {16'd0, target_q};
        OFS_RAMPDIV: rd_d = {16'd0, rampdiv_q};
        OFS_STATUS:  rd_d = {cur_q, 15'd0, (cur_q != target_q)};
        default:     rd_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) begin
      ctrl_q     <= 2'd0;
      period_q   <= 16'd999;
      target_q   <= 16'd0;
      rampdiv_q  <= 16'd0;
      cur_q      <= 16'd0;
      rc_q       <= 16'd0;
      cnt_q      <= 16'd0;
      period_a_q <= 16'd999;
      duty_a_q   <= 16'd0;
      pwm_q      <= 1'b0;
      rd_q       <= 32'd0;
      vd_q       <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      target_q   <= target_d;
      rampdiv_q  <= rampdiv_d;
      cur_q      <= cur_d;
      rc_q       <= rc_d;
      cnt_q      <= cnt_d;
      period_a_q <= period_a_d;
      duty_a_q   <= duty_a_d;
      pwm_q      <= pwm_d;
      rd_q       <= rd_d;
      vd_q       <= vd_d;
    end
  end

  assign oSUsiRd = rd_q;
  assign oSUsiVd = vd_q;
  assign oPwm    = pwm_q;

endmodule
